// File: rtl/sio_l2b_pkg.sv
// Shared types and constants for the per-bank L2B-to-SIO response receiver.
// Holds the header field positions, the read-response encoding, the beat count,
// the receive FSM state enum and the committed-packet payload struct.
package sio_l2b_pkg;

  localparam int unsigned BEATS    = 16;
  localparam int unsigned BEAT_W   = 32;
  localparam int unsigned HDR_W    = 24;
  localparam int unsigned DATA_W   = BEATS * BEAT_W;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned PAR_W    = 2;

  // Header field positions inside the 32-bit header word
  localparam int unsigned OPES_HI  = 23;
  localparam int unsigned OPES_LO  = 20;
  localparam int unsigned CBA_HI   = 19;
  localparam int unsigned CBA_LO   = 16;
  localparam int unsigned TAG_HI   = 15;
  localparam int unsigned TAG_LO   = 0;

  // opes[1:0] value that marks a read response carrying BEATS data beats
  localparam logic [1:0] OPES_RD   = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } rcv_state_e;

  typedef struct packed {
    logic [HDR_W-1:0]  hdr;
    logic              has_data;
    logic [DATA_W-1:0] data;
    logic              par_err;
    logic              ue_err;
  } pkt_t;

  // True when the header announces a read response (data beats follow)
  function automatic logic is_read(input logic [HDR_W-1:0] hdr);
    return hdr[OPES_LO+1:OPES_LO] == OPES_RD;
  endfunction

endpackage

// File: rtl/sio_l2b_rsp_rcv_if.sv
// Bundles the L2-bank response stream and the outbound packet handshake.
//   l2b_sio_*         : header/data stream from the L2 bank (into the receiver)
//   rsp_vld/rsp_rdy   : valid/ready handshake for the buffered head packet
//   rsp_hdr/has_data/data/par_err/ue_err : head packet payload
//   ovf_err/proto_err : sticky error flags
// slave is the receiver side, master is the L2 bank plus outbound consumer side.
interface sio_l2b_rsp_rcv_if;
  import sio_l2b_pkg::*;

  logic                l2b_sio_ctag_vld;
  logic [BEAT_W-1:0]   l2b_sio_data;
  logic [PAR_W-1:0]    l2b_sio_parity;
  logic                l2b_sio_ue_err;

  logic                rsp_vld;
  logic                rsp_rdy;
  logic [HDR_W-1:0]    rsp_hdr;
  logic                rsp_has_data;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_par_err;
  logic                rsp_ue_err;
  logic                ovf_err;
  logic                proto_err;

  modport slave (
    input  l2b_sio_ctag_vld, l2b_sio_data, l2b_sio_parity, l2b_sio_ue_err, rsp_rdy,
    output rsp_vld, rsp_hdr, rsp_has_data, rsp_data, rsp_par_err, rsp_ue_err,
           ovf_err, proto_err
  );

  modport master (
    output l2b_sio_ctag_vld, l2b_sio_data, l2b_sio_parity, l2b_sio_ue_err, rsp_rdy,
    input  rsp_vld, rsp_hdr, rsp_has_data, rsp_data, rsp_par_err, rsp_ue_err,
           ovf_err, proto_err
  );

endinterface

// File: rtl/sio_l2b_rsp_fifo.sv
// Two-entry in-order packet buffer. The head entry is its own register so the
// consumer-facing payload is always a flop output; a pop shifts the tail into
// the head, giving a zero-bubble handoff. Push while full is ignored unless a
// pop happens in the same cycle.
//   clk, rst  : clock, async active-high reset
//   push/push_pkt : commit request and payload
//   pop       : head consumed this cycle (ignored when empty)
//   full      : both entries occupied
//   head_vld/head : head entry valid and payload
module sio_l2b_rsp_fifo
  import sio_l2b_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  pkt_t push_pkt,
  input  logic pop,
  output logic full,
  output logic head_vld,
  output pkt_t head
);

  pkt_t tail;
  logic tail_vld;
  logic pop_c;

  assign pop_c = pop & head_vld;
  assign full  = tail_vld;

  // Head/tail update; simultaneous pop+push keeps occupancy unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else if (pop_c) begin
      if (tail_vld) begin
        head <= tail;
        if (push) tail     <= push_pkt;
        else      tail_vld <= 1'b0;
      end else if (push) begin
        head <= push_pkt;
      end else begin
        head_vld <= 1'b0;
      end
    end else if (push) begin
      if (!head_vld) begin
        head     <= push_pkt;
        head_vld <= 1'b1;
      end else if (!tail_vld) begin
        tail     <= push_pkt;
        tail_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sio_l2b_rsp_rcv.sv
// Per-bank receiver for the L2-bank-to-SIO response stream. Captures a header,
// collects BEATS data beats for read responses, checks per-halfword even parity,
// and commits complete packets into a 2-entry buffer presented with valid/ready.
//   iol2clk : clock
//   rst     : async active-high reset
//   bus     : slave side of sio_l2b_rsp_rcv_if (stream in, packet out, sticky errors)
module sio_l2b_rsp_rcv
  import sio_l2b_pkg::*;
(
  input  logic                 iol2clk,
  input  logic                 rst,
  sio_l2b_rsp_rcv_if.slave     bus
);

  rcv_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  pkt_t              stg, stg_nxt;
  logic              push_c;
  logic              pop_c;
  logic              proto_set_c;
  logic              par_bad_c;
  logic              fifo_full;
  logic              head_vld;
  pkt_t              head;

  // A data beat mismatches when either halfword's even-parity bit disagrees
  assign par_bad_c = (bus.l2b_sio_parity[1] != ^bus.l2b_sio_data[31:16]) |
                     (bus.l2b_sio_parity[0] != ^bus.l2b_sio_data[15:0]);

  assign pop_c = head_vld & bus.rsp_rdy;

  // State, beat counter, staging and sticky flags
  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      stg           <= '0;
      bus.ovf_err   <= 1'b0;
      bus.proto_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      stg           <= stg_nxt;
      bus.ovf_err   <= bus.ovf_err | (push_c & fifo_full & ~pop_c);
      bus.proto_err <= bus.proto_err | proto_set_c;
    end
  end

  // Next state; stg_nxt doubles as the commit payload so acks and the final
  // beat are pushed in the same cycle they arrive
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    stg_nxt     = stg;
    push_c      = 1'b0;
    proto_set_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.l2b_sio_ctag_vld) begin
          stg_nxt          = '0;
          stg_nxt.hdr      = bus.l2b_sio_data[HDR_W-1:0];
          stg_nxt.has_data = is_read(bus.l2b_sio_data[HDR_W-1:0]);
          cnt_nxt          = '0;
          if (stg_nxt.has_data) state_nxt = ST_DATA;
          else                  push_c    = 1'b1;
        end
      end
      ST_DATA: begin
        // A stray header strobe here is flagged but the cycle stays a beat
        proto_set_c = bus.l2b_sio_ctag_vld;
        stg_nxt.data[BEAT_W*int'(cnt) +: BEAT_W] = bus.l2b_sio_data;
        stg_nxt.par_err = stg.par_err | par_bad_c;
        stg_nxt.ue_err  = stg.ue_err | bus.l2b_sio_ue_err;
        cnt_nxt         = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BEATS - 1)) begin
          push_c    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sio_l2b_rsp_fifo u_fifo (
    .clk      (iol2clk),
    .rst      (rst),
    .push     (push_c),
    .push_pkt (stg_nxt),
    .pop      (pop_c),
    .full     (fifo_full),
    .head_vld (head_vld),
    .head     (head)
  );

  assign bus.rsp_vld      = head_vld;
  assign bus.rsp_hdr      = head.hdr;
  assign bus.rsp_has_data = head.has_data;
  assign bus.rsp_data     = head.data;
  assign bus.rsp_par_err  = head.par_err;
  assign bus.rsp_ue_err   = head.ue_err;

endmodule

// File: doc/sio_l2b_rsp_rcv.md
# sio_l2b_rsp_rcv

Per-bank receive stage in the SIO that consumes the L2-bank-to-SIO response stream (`ctag_vld`, 32-bit data, 2-bit parity, `ue_err`) of one L2 bank. It captures the header cycle and, for read responses, the 16 following data beats, then checks parity. Complete packets are committed into a 2-entry buffer and presented to the SIO outbound logic with a valid/ready handshake. Eight instances, one per bank, sit directly downstream of the L2 banks.

## Interface
- `BEATS`, 16: data beats following a read-response header (64 B line).
- `DEPTH`, 2: committed-packet buffer depth (fixed at 2; other values are not supported).
- `iol2clk`  in  1  I/O-L2 clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `l2b_sio_ctag_vld`  in  1  header-cycle strobe from the L2 bank.
- `l2b_sio_data`  in  32  header: [23:20] opes, [19:16] cba, [15:0] tag; otherwise data beat.
- `l2b_sio_parity`  in  2  [1] even parity over data[31:16], [0] even parity over data[15:0]; checked on data beats only.
- `l2b_sio_ue_err`  in  1  L2 uncorrectable error, sampled on data beats.
- `rsp_vld`  out  1  a committed packet is at the buffer head.
- `rsp_rdy`  in  1  consumer accepts the head packet when `rsp_vld & rsp_rdy`.
- `rsp_hdr`  out  24  header bits [23:0] of the head packet.
- `rsp_has_data`  out  1  the head packet carries 16 data beats.
- `rsp_data`  out  512  beat k occupies bits [32k+31:32k]; zero when `rsp_has_data`=0.
- `rsp_par_err`  out  1  one or more parity mismatches in the head packet.
- `rsp_ue_err`  out  1  `ue_err` was seen on one or more beats of the head packet.
- `ovf_err`  out  1  sticky: a completed packet was dropped because the buffer was full.
- `proto_err`  out  1  sticky: `ctag_vld` was asserted during the data phase.

## Operation
- Opes encoding: opes[1:0]=2'b01 is a read response followed by `BEATS` data beats. All other values are header-only acks (WR8, WRI).
- FSM `IDLE`/`DATA`.
  - `IDLE` + `ctag_vld`: latch the header into staging and clear the staging error flags. A read response goes to `DATA` with beat counter 0; an ack commits immediately and stays `IDLE`.
  - `DATA`: every cycle is a beat. Write the beat into staging slot `cnt`, OR parity-mismatch and `ue_err` into the staging flags, and increment `cnt`. On `cnt`=`BEATS`-1, commit and return to `IDLE`.
  - `ctag_vld` in `DATA`: set `proto_err`, treat the cycle as a data beat anyway, and do not start a new header.
- Commit: push staging into the buffer. If the buffer is full and no pop occurs that same cycle, drop the packet and set `ovf_err`. Pop and push in the same cycle with a full buffer is accepted.
- Buffer: 2-entry FIFO with in-order pop. `rsp_*` outputs are driven from the head entry.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: FSM `IDLE`; `cnt`=0; buffer empty; `rsp_vld`=0; `rsp_hdr`, `rsp_data`, `rsp_has_data`, `rsp_par_err`, `rsp_ue_err`, `ovf_err`, `proto_err` all 0.
- Reset asserted mid-packet discards staging and buffer contents immediately.
- Read response: header at cycle T, beats at T+1..T+16, `rsp_vld` high at T+17 if the buffer was empty.
- Ack: header at T, `rsp_vld` at T+1.
- Back-to-back: a new header is accepted at T+17, the cycle after the last beat.
- Outputs are registered. `rsp_*` hold stable while `rsp_vld & !rsp_rdy`.
- After a pop, the next entry is visible the following cycle (zero-bubble).

## Structure
- Package `sio_l2b_pkg` holds:
  - the opes field positions and the read encoding constant;
  - `BEATS`;
  - the FSM state enum;
  - the packet struct (hdr, has_data, data, par_err, ue_err).
- Sub-module `sio_l2b_rsp_fifo`: 2-entry packet FIFO with push/pop/full/empty, simultaneous push+pop legal when full.
- Top level contains the FSM, beat counter, staging register and parity checker.

## Test plan
- Read response: header opes=4'h1, cba=4'h3, tag=16'hBEEF, beats 32'h0..32'hF with correct parity. Expect `rsp_vld` at T+17, `rsp_hdr`=24'h13BEEF, beat k = k, both error flags 0.
- Ack: header opes=4'h2, tag=16'h0042. Expect `rsp_vld` at T+1, `rsp_has_data`=0, `rsp_data`=0.
- Error flags: flip `parity[0]` on beat 5 and assert `ue_err` on beat 9. Expect `rsp_par_err`=1 and `rsp_ue_err`=1; the next clean packet shows both at 0.
- Overflow: `rsp_rdy`=0, send three acks. Expect two buffered, `ovf_err`=1 after the third. Raise `rsp_rdy` on the third commit cycle in a rerun and expect no overflow.
- Protocol error: `ctag_vld` on beat 7. Expect `proto_err`=1, the packet still commits after 16 beats, and the beat-7 data is stored.
- Reset: assert `rst` at beat 8. Expect all outputs 0 and no `rsp_vld` afterwards until a new header arrives.
